decode_buffer: RTL
==================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 2, meaning log2(DEPTH).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 flush  in  1  synchronous queue clear.
REQ-007 in_valid  in  1  fetch offers an instruction.
REQ-008 in_ready  out  1  buffer accepts (= !full).
REQ-009 in_instr  in  32  instruction word.
REQ-010 in_pc  in  32  instruction address.
REQ-011 out_valid  out  1  head entry present (= !empty).
REQ-012 out_ready  in  1  execute side consumes head.
REQ-013 out_instr, out_pc  out  32 each  head entry fields.
REQ-014 out_ctrl  out  11  {regwrite,regdst,alusrc,branch,memtoreg,jump,jal,jr,bal,hilo,memen}.
REQ-015 out_cp0_wen  out  1  head is MTC0.
REQ-016 out_invalid  out  1  head is reserved instruction.
REQ-017 count  out  AW+1  occupied entries.

Function
REQ-018 Decode SHALL be combinational on in_instr and stored with the entry at push; op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0]; vectors below written as out_ctrl MSB..LSB.
REQ-019 op 0C,0D,0E,0F,08,09,0A,0B -> 10100000000.
REQ-020 Loads op 20,24,21,25,23 -> 10101000001; stores op 28,29,2B -> 00100000001.
REQ-021 op 02 (J) -> 00000100000; op 03 (JAL) -> 10000010000; op 04,05,06,07 -> 00010000000.
REQ-022 op 01: rt 00/01 -> 00010000000; rt 10/11 -> 10010000100; other rt invalid.
REQ-023 op 10: rs 04 (MTC0) -> all zero, cp0_wen=1; rs 00 (MFC0) -> 10001000000; rs 10 (ERET) -> all zero; other rs invalid.
REQ-024 op 00 by funct: 0C,0D -> all zero; 11,13,18,19,1A,1B -> 00000000010; 08 (JR) -> 00000101000; 09 (JALR) -> 11000001000; 10,12,20,21,22,23,2A,2B,24,25,26,27,00,02,03,04,06,07 -> 11000000000; other funct invalid.
REQ-025 Any other op SHALL be invalid; invalid entries SHALL carry out_ctrl=0, cp0_wen=0, invalid=1.
REQ-026 cp0_wen SHALL be 1 only for op 10 with rs 04.
REQ-027 Push occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
REQ-028 Storage SHALL be circular: wr_ptr/rd_ptr AW bits, wrap from DEPTH-1 to 0; count tracks occupancy 0..DEPTH.
REQ-029 Latency: entry pushed at edge N SHALL appear on out_* after edge N; no same-cycle bypass.
REQ-030 out_* SHALL be driven from the entry at rd_ptr; out_* undefined-safe (hold last storage) when empty, only out_valid qualifies.
REQ-031 Push and pop in same cycle SHALL leave count unchanged and advance both pointers.
REQ-032 When full, in_ready=0 even if out_ready=1 (no pass-through push).
REQ-033 Pop when empty and push when full SHALL be ignored; pointers and count unchanged.
REQ-034 flush SHALL have priority: at the edge, rd_ptr=wr_ptr=0, count=0; simultaneous push/pop discarded.
REQ-035 Entry payload (instr, pc, ctrl, cp0_wen, invalid) SHALL be held unchanged while resident.

Reset
REQ-036 rst SHALL asynchronously clear wr_ptr, rd_ptr, count to 0; in_ready=1, out_valid=0 immediately.
REQ-037 Reset mid-operation SHALL discard all entries; storage array need not be cleared.

Verification
REQ-038 Push 0x8C820004 (LW) into empty buffer -> next cycle out_valid=1, out_ctrl=10101000001, count=1.
REQ-039 Push 4 entries with out_ready=0 (DEPTH=4) -> count=4, in_ready=0; 5th offer not accepted; pop all in order, pc sequence preserved across pointer wrap.
REQ-040 Full buffer, in_valid=1 and out_ready=1 -> one pop only, count=3; next cycle push accepted.
REQ-041 Push 0x40826000 (MTC0) then 0xFC000000 -> first head cp0_wen=1, ctrl=0; second invalid=1, ctrl=0.
REQ-042 count=2 with flush=1, in_valid=1 -> count=0, out_valid=0 next cycle; pushed word lost.
REQ-043 rst asserted between edges with count=3 -> out_valid=0, count=0 before next edge.

Source files
------------

// File: rtl/decode_buffer.sv
// decode_buffer
// Circular queue between fetch and execute. Each pushed instruction is
// decoded on the way in, and the decoded control bits are stored with it.
//
// Parameters
//   DEPTH  number of queue entries (power of two, at least 2)
//   AW     log2(DEPTH), the pointer width
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               synchronous clear of the whole queue
//   in_valid/in_ready   fetch-side handshake (in_ready = not full)
//   in_instr, in_pc     instruction word and its address
//   out_valid/out_ready execute-side handshake (out_valid = not empty)
//   out_instr, out_pc   head entry fields
//   out_ctrl            {regwrite,regdst,alusrc,branch,memtoreg,jump,jal,jr,bal,hilo,memen}
//   out_cp0_wen         head entry is MTC0
//   out_invalid         head entry is a reserved instruction
//   count               number of occupied entries, 0..DEPTH
module decode_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output logic [10:0]   out_ctrl,
    output logic          out_cp0_wen,
    output logic          out_invalid,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    logic [31:0] mem_instr   [DEPTH];
    logic [31:0] mem_pc      [DEPTH];
    logic [10:0] mem_ctrl    [DEPTH];
    logic        mem_cp0_wen [DEPTH];
    logic        mem_invalid [DEPTH];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [10:0] dec_ctrl;
    logic        dec_cp0_wen;
    logic        dec_invalid;

    assign op    = in_instr[31:26];
    assign rs    = in_instr[25:21];
    assign rt    = in_instr[20:16];
    assign funct = in_instr[5:0];

    // Full blocks pushes even when the head is leaving this cycle, so a
    // full queue never accepts a pass-through entry.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Instruction decode. Anything not recognised is flagged invalid and
    // carries an all-zero control vector so it can never write state.
    always_comb begin
        dec_ctrl    = '0;
        dec_cp0_wen = 1'b0;
        dec_invalid = 1'b0;
        case (op)
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: dec_ctrl = 11'b10100000000;
            6'h20, 6'h21, 6'h23,
            6'h24, 6'h25:               dec_ctrl = 11'b10101000001;
            6'h28, 6'h29, 6'h2B:        dec_ctrl = 11'b00100000001;
            6'h02:                      dec_ctrl = 11'b00000100000;
            6'h03:                      dec_ctrl = 11'b10000010000;
            6'h04, 6'h05, 6'h06, 6'h07: dec_ctrl = 11'b00010000000;
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: dec_ctrl = 11'b00010000000;
                    5'h10, 5'h11: dec_ctrl = 11'b10010000100;
                    default:      dec_invalid = 1'b1;
                endcase
            end
            6'h10: begin
                case (rs)
                    5'h04:   dec_cp0_wen = 1'b1;
                    5'h00:   dec_ctrl = 11'b10001000000;
                    5'h10:   dec_ctrl = '0;
                    default: dec_invalid = 1'b1;
                endcase
            end
            6'h00: begin
                case (funct)
                    6'h0C, 6'h0D:          dec_ctrl = '0;
                    6'h11, 6'h13, 6'h18,
                    6'h19, 6'h1A, 6'h1B:   dec_ctrl = 11'b00000000010;
                    6'h08:                 dec_ctrl = 11'b00000101000;
                    6'h09:                 dec_ctrl = 11'b11000001000;
                    6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07:
                                           dec_ctrl = 11'b11000000000;
                    default:               dec_invalid = 1'b1;
                endcase
            end
            default: dec_invalid = 1'b1;
        endcase
    end

    // Pointer and occupancy bookkeeping. Flush wins over any handshake in
    // the same cycle. Pointers are exactly AW bits wide, so incrementing
    // past DEPTH-1 wraps to 0 on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload storage. It is not reset because only the pointers decide
    // which slots are live, and an entry is written once and then left alone
    // until it is popped.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_instr[wr_ptr]   <= in_instr;
            mem_pc[wr_ptr]      <= in_pc;
            mem_ctrl[wr_ptr]    <= dec_ctrl;
            mem_cp0_wen[wr_ptr] <= dec_cp0_wen;
            mem_invalid[wr_ptr] <= dec_invalid;
        end
    end

    // The head is read straight from storage. When the queue is empty these
    // show stale contents and only out_valid says whether they mean anything.
    assign out_instr   = mem_instr[rd_ptr];
    assign out_pc      = mem_pc[rd_ptr];
    assign out_ctrl    = mem_ctrl[rd_ptr];
    assign out_cp0_wen = mem_cp0_wen[rd_ptr];
    assign out_invalid = mem_invalid[rd_ptr];

endmodule
